// File: rtl/sort_mem_resp.sv
// Sort-array responder: two initiator ports (A = swap unit, B = compare/partition unit),
// round-robin arbitration with a swap lock, one access per cycle, read data one cycle after grant.
module sort_mem_resp #(
   parameter int WORD_SIZE = 16,
   parameter int DEPTH     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_req,
   input  logic                 a_we,
   input  logic                 a_lock,
   input  logic [WORD_SIZE-1:0] a_addr,
   input  logic [WORD_SIZE-1:0] a_wdata,
   output logic                 a_gnt,
   output logic                 a_rvalid,
   output logic [WORD_SIZE-1:0] a_rdata,
   output logic                 a_err,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic                 b_lock,
   input  logic [WORD_SIZE-1:0] b_addr,
   input  logic [WORD_SIZE-1:0] b_wdata,
   output logic                 b_gnt,
   output logic                 b_rvalid,
   output logic [WORD_SIZE-1:0] b_rdata,
   output logic                 b_err,
   output logic                 init_done
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_A,
      OWN_B
   } owner_t;

   state_t               state_q, state_d;
   owner_t               owner_q, owner_d;
   logic                 last_b_q, last_b_d;
   logic [AW-1:0]        init_cnt_q, init_cnt_d;
   logic                 init_done_q, init_done_d;
   logic                 a_rvalid_q, a_rvalid_d;
   logic                 a_err_q, a_err_d;
   logic [WORD_SIZE-1:0] a_rdata_q, a_rdata_d;
   logic                 b_rvalid_q, b_rvalid_d;
   logic                 b_err_q, b_err_d;
   logic [WORD_SIZE-1:0] b_rdata_q, b_rdata_d;

   logic [WORD_SIZE-1:0] mem_q [DEPTH];

   logic                 a_in_range, b_in_range;
   logic                 sel_we, sel_in_range;
   logic [WORD_SIZE-1:0] sel_addr, sel_wdata;
   logic [WORD_SIZE-1:0] rd_word;
   logic                 mem_we;
   logic [AW-1:0]        mem_waddr;
   logic [WORD_SIZE-1:0] mem_wdata;

   // Range check uses the full bus width so high address bits never alias into the array.
   assign a_in_range = (a_addr < WORD_SIZE'(DEPTH));
   assign b_in_range = (b_addr < WORD_SIZE'(DEPTH));

   // Grant: nothing during the clear sweep; a lock owner excludes the other port entirely.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (state_q == ST_RUN) begin
         case (owner_q)
            OWN_A:   a_gnt = a_req;
            OWN_B:   b_gnt = b_req;
            default: begin
               if (a_req && b_req) begin
                  a_gnt = last_b_q;
                  b_gnt = !last_b_q;
               end else begin
                  a_gnt = a_req;
                  b_gnt = b_req;
               end
            end
         endcase
      end
   end

   // At most one grant per cycle, so a single shared access path serves both ports.
   always_comb begin
      sel_we       = a_gnt ? a_we       : b_we;
      sel_addr     = a_gnt ? a_addr     : b_addr;
      sel_wdata    = a_gnt ? a_wdata    : b_wdata;
      sel_in_range = a_gnt ? a_in_range : b_in_range;
   end

   assign rd_word = mem_q[sel_addr[AW-1:0]];

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (state_q == ST_INIT) begin
         mem_we    = 1'b1;
         mem_waddr = init_cnt_q;
      end else if ((a_gnt || b_gnt) && sel_we && sel_in_range) begin
         mem_we    = 1'b1;
         mem_waddr = sel_addr[AW-1:0];
         mem_wdata = sel_wdata;
      end
   end

   // NOTE: the array has no reset; the INIT sweep clears it after every reset instead.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_b_d    = last_b_q;
      init_cnt_d  = init_cnt_q;
      init_done_d = init_done_q;
      a_rvalid_d  = 1'b0;
      a_err_d     = 1'b0;
      a_rdata_d   = a_rdata_q;
      b_rvalid_d  = 1'b0;
      b_err_d     = 1'b0;
      b_rdata_d   = b_rdata_q;

      if (state_q == ST_INIT) begin
         init_cnt_d = init_cnt_q + AW'(1);
         if (init_cnt_q == AW'(DEPTH - 1)) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
         end
      end

      if (a_gnt) begin
         owner_d    = a_lock ? OWN_A : OWN_NONE;
         last_b_d   = 1'b0;
         a_rvalid_d = !a_we || !a_in_range;
         a_err_d    = !a_in_range;
         if (!a_in_range) begin
            a_rdata_d = '0;
         end else if (!a_we) begin
            a_rdata_d = rd_word;
         end
      end

      if (b_gnt) begin
         owner_d    = b_lock ? OWN_B : OWN_NONE;
         last_b_d   = 1'b1;
         b_rvalid_d = !b_we || !b_in_range;
         b_err_d    = !b_in_range;
         if (!b_in_range) begin
            b_rdata_d = '0;
         end else if (!b_we) begin
            b_rdata_d = rd_word;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         owner_q     <= OWN_NONE;
         last_b_q    <= 1'b1;
         init_cnt_q  <= '0;
         init_done_q <= 1'b0;
         a_rvalid_q  <= 1'b0;
         a_err_q     <= 1'b0;
         a_rdata_q   <= '0;
         b_rvalid_q  <= 1'b0;
         b_err_q     <= 1'b0;
         b_rdata_q   <= '0;
      end else begin
         // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_b_q    <= last_b_d;
         init_cnt_q  <= init_cnt_d;
         init_done_q <= init_done_d;
         a_rvalid_q  <= a_rvalid_d;
         a_err_q     <= a_err_d;
         a_rdata_q   <= a_rdata_d;
         b_rvalid_q  <= b_rvalid_d;
         b_err_q     <= b_err_d;
         b_rdata_q   <= b_rdata_d;
      end
   end

   assign a_rvalid  = a_rvalid_q;
   assign a_err     = a_err_q;
   assign a_rdata   = a_rdata_q;
   assign b_rvalid  = b_rvalid_q;
   assign b_err     = b_err_q;
   assign b_rdata   = b_rdata_q;
   assign init_done = init_done_q;

   a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(a_gnt && b_gnt));

endmodule

// File: tb/tb_sort_mem_resp.sv
// Bench for sort_mem_resp: per-port request queues, a cycle-level behavioural model checked
// every cycle, and literal expectations for the directed scenarios.
module tb_sort_mem_resp;

   localparam int W = 16;
   localparam int D = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
   logic [W-1:0] a_addr = '0, a_wdata = '0;
   logic         a_gnt, a_rvalid, a_err;
   logic [W-1:0] a_rdata;
   logic         b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
   logic [W-1:0] b_addr = '0, b_wdata = '0;
   logic         b_gnt, b_rvalid, b_err;
   logic [W-1:0] b_rdata;
   logic         init_done;

   sort_mem_resp #(.WORD_SIZE(W), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
      .init_done(init_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         we;
      logic         lock;
      logic [W-1:0] addr;
      logic [W-1:0] wdata;
   } op_t;

   op_t a_q[$];
   op_t b_q[$];
   bit  a_took = 1'b0, b_took = 1'b0;
   int  n_err = 0, n_chk = 0;
   int  a_log[$], b_log[$], g_log[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   // Drivers: present the queue head, hold it until the port was granted.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (a_took && a_q.size() > 0) void'(a_q.pop_front());
         if (b_took && b_q.size() > 0) void'(b_q.pop_front());
         if (a_q.size() > 0) begin
            a_req = 1'b1; a_we = a_q[0].we; a_lock = a_q[0].lock;
            a_addr = a_q[0].addr; a_wdata = a_q[0].wdata;
         end else begin
            a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
         end
         if (b_q.size() > 0) begin
            b_req = 1'b1; b_we = b_q[0].we; b_lock = b_q[0].lock;
            b_addr = b_q[0].addr; b_wdata = b_q[0].wdata;
         end else begin
            b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = '0; b_wdata = '0;
         end
      end
   end

   // Behavioural model: array contents, owner (0 none, 1 A, 2 B), last granted port,
   // and the response each port must show in the following cycle.
   logic [W-1:0] m_mem [D];
   int           m_cnt = 0, m_owner = 0;
   bit           m_done = 1'b0, m_last_b = 1'b1;
   bit           g_a, g_b;
   bit           e_a_rv = 1'b0, e_a_err = 1'b0, e_b_rv = 1'b0, e_b_err = 1'b0;
   logic [W-1:0] e_a_rd = '0, e_b_rd = '0;

   task automatic serve(input bit is_b, input op_t op);
      bit           rv, er;
      logic [W-1:0] rd;
      rd = is_b ? e_b_rd : e_a_rd;
      if (int'(op.addr) >= D) begin
         rv = 1'b1; er = 1'b1; rd = '0;
      end else if (op.we) begin
         m_mem[op.addr] = op.wdata; rv = 1'b0; er = 1'b0;
      end else begin
         rv = 1'b1; er = 1'b0; rd = m_mem[op.addr];
      end
      m_owner  = op.lock ? (is_b ? 2 : 1) : 0;
      m_last_b = is_b;
      if (is_b) begin e_b_rv = rv; e_b_err = er; e_b_rd = rd; end
      else      begin e_a_rv = rv; e_a_err = er; e_a_rd = rd; end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         m_cnt = 0; m_done = 1'b0; m_owner = 0; m_last_b = 1'b1;
         e_a_rv = 1'b0; e_a_err = 1'b0; e_a_rd = '0;
         e_b_rv = 1'b0; e_b_err = 1'b0; e_b_rd = '0;
         a_took = 1'b0; b_took = 1'b0;
         check("rst_outputs", {a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, init_done}, 0);
         check("rst_rdata", {a_rdata, b_rdata}, 0);
      end else begin
         g_a = 1'b0; g_b = 1'b0;
         if (m_done) begin
            if (m_owner == 1)      g_a = a_req;
            else if (m_owner == 2) g_b = b_req;
            else if (a_req && b_req) begin
               g_a = m_last_b; g_b = !m_last_b;
            end else begin
               g_a = a_req; g_b = b_req;
            end
         end
         check("a_gnt", a_gnt, g_a);
         check("b_gnt", b_gnt, g_b);
         check("a_rvalid", a_rvalid, e_a_rv);
         check("a_err", a_err, e_a_err);
         check("a_rdata", a_rdata, e_a_rd);
         check("b_rvalid", b_rvalid, e_b_rv);
         check("b_err", b_err, e_b_err);
         check("b_rdata", b_rdata, e_b_rd);
         check("init_done", init_done, m_done);
         a_took = a_gnt; b_took = b_gnt;
         if (a_rvalid) a_log.push_back(int'({a_err, a_rdata}));
         if (b_rvalid) b_log.push_back(int'({b_err, b_rdata}));
         if (a_gnt) g_log.push_back(1);
         if (b_gnt) g_log.push_back(2);

         e_a_rv = 1'b0; e_a_err = 1'b0; e_b_rv = 1'b0; e_b_err = 1'b0;
         if (!m_done) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == D) m_done = 1'b1;
         end else if (g_a) begin
            serve(1'b0, {a_we, a_lock, a_addr, a_wdata});
         end else if (g_b) begin
            serve(1'b1, {b_we, b_lock, b_addr, b_wdata});
         end
      end
   end

   task automatic push(input bit to_b, input logic we, input logic lock,
                       input logic [W-1:0] addr, input logic [W-1:0] wdata);
      op_t op;
      op.we = we; op.lock = lock; op.addr = addr; op.wdata = wdata;
      if (to_b) b_q.push_back(op);
      else      a_q.push_back(op);
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((a_q.size() > 0 || b_q.size() > 0) && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", k < 300, 1);
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      a_log.delete(); b_log.delete(); g_log.delete();
   endtask

   task automatic wait_init(input string name);
      int k = 0;
      while (!init_done && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      check(name, k, D);
      @(negedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_init("init_latency");

      // Both ports read every cycle: alternating grants, A first after reset.
      clear_logs();
      for (int i = 0; i < 4; i++) begin
         push(1'b0, 1'b0, 1'b0, W'(i), '0);
         push(1'b1, 1'b0, 1'b0, W'(i + 4), '0);
      end
      wait_idle();
      check("alt_count", g_log.size(), 8);
      for (int i = 0; i < 8; i++) check("alt_order", qget(g_log, i), (i % 2 == 0) ? 1 : 2);
      for (int i = 0; i < 4; i++) begin
         check("init_zero_a", qget(a_log, i), 0);
         check("init_zero_b", qget(b_log, i), 0);
      end

      clear_logs();
      for (int i = 8; i < D; i++) push(1'b0, 1'b0, 1'b0, W'(i), '0);
      wait_idle();
      for (int i = 0; i < 8; i++) check("init_zero_hi", qget(a_log, i), 0);

      // Write then read on the other port the next cycle.
      clear_logs();
      push(1'b0, 1'b1, 1'b0, 16'd0, 16'd9);
      @(negedge clk);
      #1;
      push(1'b1, 1'b0, 1'b0, 16'd0, '0);
      wait_idle();
      check("wr_rd_data", qget(b_log, 0), 9);

      // Atomic swap of addr 4 and 7 while B requests continuously.
      push(1'b0, 1'b1, 1'b0, 16'd4, 16'd5);
      push(1'b0, 1'b1, 1'b0, 16'd7, 16'd2);
      wait_idle();
      push(1'b1, 1'b0, 1'b0, 16'd1, '0);
      wait_idle();
      clear_logs();
      push(1'b0, 1'b0, 1'b1, 16'd4, '0);
      push(1'b0, 1'b0, 1'b1, 16'd7, '0);
      push(1'b0, 1'b1, 1'b1, 16'd4, 16'd2);
      push(1'b0, 1'b1, 1'b0, 16'd7, 16'd5);
      for (int i = 0; i < 6; i++) push(1'b1, 1'b0, 1'b0, 16'd1, '0);
      wait_idle();
      for (int i = 0; i < 4; i++) check("swap_a_first", qget(g_log, i), 1);
      check("swap_b_after", qget(g_log, 4), 2);
      check("swap_rd4", qget(a_log, 0), 5);
      check("swap_rd7", qget(a_log, 1), 2);
      clear_logs();
      push(1'b0, 1'b0, 1'b0, 16'd4, '0);
      push(1'b0, 1'b0, 1'b0, 16'd7, '0);
      wait_idle();
      check("swap_mem4", qget(a_log, 0), 2);
      check("swap_mem7", qget(a_log, 1), 5);

      // Out-of-range read and write.
      clear_logs();
      push(1'b1, 1'b0, 1'b0, 16'd16, '0);
      push(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h1234);
      wait_idle();
      check("oor_b_read", qget(b_log, 0), 32'h10000);
      check("oor_a_write", qget(a_log, 0), 32'h10000);
      push(1'b0, 1'b0, 1'b0, 16'd0, '0);
      push(1'b0, 1'b0, 1'b0, 16'd15, '0);
      wait_idle();
      check("oor_mem0", qget(a_log, 1), 9);
      check("oor_mem15", qget(a_log, 2), 0);

      // Reset while A holds the lock mid-swap.
      clear_logs();
      push(1'b0, 1'b0, 1'b1, 16'd4, '0);
      push(1'b0, 1'b0, 1'b1, 16'd7, '0);
      wait_idle();
      push(1'b1, 1'b0, 1'b0, 16'd4, '0);
      repeat (3) @(negedge clk);
      check("lock_blocks_b", b_q.size(), 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_now_flags", {a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, init_done}, 0);
      check("rst_now_rdata", {a_rdata, b_rdata}, 0);
      a_q.delete();
      b_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_init("reinit_latency");
      clear_logs();
      push(1'b1, 1'b0, 1'b0, 16'd4, '0);
      wait_idle();
      check("post_rst_b_gnt", qget(g_log, 0), 2);
      check("post_rst_b_data", qget(b_log, 0), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
